// File: rtl/ex_stage_mdu_if.sv
// Decode-to-execute handshake bundle: instruction fields plus valid/allowin.
// The decode side is the master; the execute stage is the slave.
interface ex_stage_mdu_if #(
    parameter int XLEN   = 32,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
);
    logic              ds_to_es_valid;
    logic              es_allowin;
    logic [PC_W-1:0]   ds_pc;
    logic [2:0]        ds_op;
    logic              ds_gr_we;
    logic [DEST_W-1:0] ds_dest;
    logic [XLEN-1:0]   ds_src1;
    logic [XLEN-1:0]   ds_src2;
    logic [XLEN-1:0]   ds_st_data;
    logic [1:0]        ds_mem_size;

    modport master (
        output ds_to_es_valid, ds_pc, ds_op, ds_gr_we, ds_dest,
               ds_src1, ds_src2, ds_st_data, ds_mem_size,
        input  es_allowin
    );

    modport slave (
        input  ds_to_es_valid, ds_pc, ds_op, ds_gr_we, ds_dest,
               ds_src1, ds_src2, ds_st_data, ds_mem_size,
        output es_allowin
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// Execute stage: add/address path, iterative restoring divider and
// data-SRAM byte-lane generation behind a valid/allowin pipeline handshake.
module ex_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 ms_allowin,
    ex_stage_mdu_if.slave        ds,
    output logic                 es_to_ms_valid,
    output logic [PC_W-1:0]      es_pc,
    output logic [XLEN-1:0]      es_result,
    output logic                 es_gr_we,
    output logic [DEST_W-1:0]    es_dest,
    output logic                 es_res_from_mem,
    output logic                 es_fw_valid,
    output logic                 es_fw_data_ok,
    output logic [XLEN-1:0]      es_fw_data,
    output logic                 data_sram_en,
    output logic [XLEN/8-1:0]    data_sram_we,
    output logic [XLEN-1:0]      data_sram_addr,
    output logic [XLEN-1:0]      data_sram_wdata
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;
    localparam logic [2:0] OP_MODU  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    logic              es_valid_q, es_valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        op_q, op_d;
    logic              gr_we_q, gr_we_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d, st_data_q, st_data_d;
    logic [1:0]        mem_size_q, mem_size_d;
    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, divisor_q, divisor_d;

    logic            es_allowin, es_ready_go;
    logic            is_div, is_signed, is_load, is_store, s1, s2;
    logic [XLEN-1:0] abs1, abs2, quot_fin, rem_fin, addr;
    logic [XLEN:0]   shifted, diff;
    logic            aligned;
    logic [3:0]      nbytes, off_ext, span_end;
    logic [LANES-1:0] lane_mask;

    assign is_div    = (op_q >= OP_DIV) && (op_q <= OP_MODU);
    assign is_signed = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);

    assign es_ready_go    = ~is_div | (state_q == S_DONE);
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign ds.es_allowin  = es_allowin;
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    // Pipeline register: flush wins over a same-cycle capture.
    always_comb begin
        es_valid_d = es_valid_q;
        pc_d       = pc_q;
        op_d       = op_q;
        gr_we_d    = gr_we_q;
        dest_d     = dest_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        st_data_d  = st_data_q;
        mem_size_d = mem_size_q;
        if (flush) begin
            es_valid_d = 1'b0;
        end else if (es_allowin) begin
            es_valid_d = ds.ds_to_es_valid;
            if (ds.ds_to_es_valid) begin
                pc_d       = ds.ds_pc;
                op_d       = ds.ds_op;
                gr_we_d    = ds.ds_gr_we;
                dest_d     = ds.ds_dest;
                src1_d     = ds.ds_src1;
                src2_d     = ds.ds_src2;
                st_data_d  = ds.ds_st_data;
                mem_size_d = ds.ds_mem_size;
            end
        end
    end

    assign s1   = is_signed & src1_q[XLEN-1];
    assign s2   = is_signed & src2_q[XLEN-1];
    assign abs1 = s1 ? -src1_q : src1_q;
    assign abs2 = s2 ? -src2_q : src2_q;

    // One restoring step per BUSY cycle: shift dividend bit into the partial remainder.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, divisor_q};
        case (state_q)
            S_IDLE: begin
                if (es_valid_q && is_div) begin
                    state_d   = S_BUSY;
                    count_d   = '0;
                    quo_d     = abs1;
                    rem_d     = '0;
                    divisor_d = abs2;
                end
            end
            S_BUSY: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (es_to_ms_valid && ms_allowin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // MIN/-1 falls out naturally (|MIN| / 1 negated is MIN); only divide-by-zero is special.
    assign quot_fin = (src2_q == '0) ? '1 : ((s1 ^ s2) ? -quo_q : quo_q);
    assign rem_fin  = (src2_q == '0) ? src1_q : (s1 ? -rem_q : rem_q);

    assign addr = src1_q + src2_q;

    always_comb begin
        case (op_q)
            OP_DIV, OP_DIVU: es_result = quot_fin;
            OP_MOD, OP_MODU: es_result = rem_fin;
            default:         es_result = addr;
        endcase
    end

    always_comb begin
        case (mem_size_q)
            2'd0:    begin aligned = 1'b1;                 nbytes = 4'd1; end
            2'd1:    begin aligned = ~addr[0];             nbytes = 4'd2; end
            2'd2:    begin aligned = (addr[1:0] == 2'd0);  nbytes = 4'd4; end
            default: begin aligned = (XLEN == 64) && (addr[2:0] == 3'd0); nbytes = 4'd8; end
        endcase
    end

    assign off_ext  = 4'(addr[OFF_W-1:0]);
    assign span_end = off_ext + nbytes;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_mask[gi] = (4'(gi) >= off_ext) && (4'(gi) < span_end);
            assign data_sram_wdata[gi*8 +: 8] =
                (mem_size_q == 2'd0) ? st_data_q[7:0] :
                (mem_size_q == 2'd1) ? st_data_q[(gi%2)*8 +: 8] :
                (mem_size_q == 2'd2) ? st_data_q[(gi%4)*8 +: 8] :
                                       st_data_q[gi*8 +: 8];
        end
    endgenerate

    // Memory ops are always ready, so this is the single handoff cycle.
    assign data_sram_en   = es_valid_q & (is_load | is_store) & aligned & ~flush & ms_allowin;
    assign data_sram_we   = (data_sram_en && is_store) ? lane_mask : '0;
    assign data_sram_addr = addr;

    assign es_pc           = pc_q;
    assign es_gr_we        = gr_we_q;
    assign es_dest         = dest_q;
    assign es_res_from_mem = is_load;
    assign es_fw_valid     = es_valid_q & gr_we_q;
    assign es_fw_data_ok   = es_fw_valid & ~is_load & es_ready_go;
    assign es_fw_data      = es_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            pc_q       <= '0;
            op_q       <= '0;
            gr_we_q    <= 1'b0;
            dest_q     <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            st_data_q  <= '0;
            mem_size_q <= '0;
            state_q    <= S_IDLE;
            count_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            gr_we_q    <= gr_we_d;
            dest_q     <= dest_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            st_data_q  <= st_data_d;
            mem_size_q <= mem_size_d;
            state_q    <= state_d;
            count_q    <= count_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
        end
    end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: add path, divider results/latency,
// store lanes, flush, back-pressure and asynchronous reset.
module tb_ex_stage_mdu;
    localparam logic [2:0] OP_ADD = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MOD = 3'd5, OP_MODU = 3'd6;

    logic        clk = 1'b0;
    logic        resetn, flush, ms_allowin;
    logic        es_to_ms_valid, es_gr_we, es_res_from_mem, es_fw_valid, es_fw_data_ok;
    logic [31:0] es_pc, es_result, es_fw_data, data_sram_addr, data_sram_wdata;
    logic [4:0]  es_dest;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(32), .DEST_W(5), .PC_W(32)) ds_if ();

    ex_stage_mdu #(.XLEN(32), .DEST_W(5), .PC_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ms_allowin(ms_allowin),
        .ds(ds_if),
        .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_result(es_result),
        .es_gr_we(es_gr_we), .es_dest(es_dest), .es_res_from_mem(es_res_from_mem),
        .es_fw_valid(es_fw_valid), .es_fw_data_ok(es_fw_data_ok), .es_fw_data(es_fw_data),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] st, input logic [1:0] size, input logic [31:0] pc);
        ds_if.ds_op          = op;
        ds_if.ds_src1        = a;
        ds_if.ds_src2        = b;
        ds_if.ds_st_data     = st;
        ds_if.ds_mem_size    = size;
        ds_if.ds_pc          = pc;
        ds_if.ds_gr_we       = (op != OP_STORE);
        ds_if.ds_dest        = 5'd7;
        ds_if.ds_to_es_valid = 1'b1;
        $display("issue op=%0d a=%h b=%h st=%h size=%0d pc=%h", op, a, b, st, size, pc);
    endtask

    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        drive(op, a, b, 32'h0, 2'd2, 32'h200);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk({tag, "_stall"}, 64'(ds_if.es_allowin), 64'd0);
        n = 0;
        while (!es_to_ms_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_res"}, 64'(es_result), 64'(exp));
        tick();
        #1;
        chk({tag, "_gone"}, 64'(es_to_ms_valid), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; ms_allowin = 1'b1;
        ds_if.ds_to_es_valid = 1'b0; ds_if.ds_pc = '0; ds_if.ds_op = '0; ds_if.ds_gr_we = 1'b0;
        ds_if.ds_dest = '0; ds_if.ds_src1 = '0; ds_if.ds_src2 = '0; ds_if.ds_st_data = '0;
        ds_if.ds_mem_size = '0;
        #3;
        chk("rst_allowin", 64'(ds_if.es_allowin), 64'd1);
        chk("rst_valid", 64'(es_to_ms_valid), 64'd0);
        chk("rst_result", 64'(es_result), 64'd0);
        chk("rst_sram_en", 64'(data_sram_en), 64'd0);
        tick();
        resetn = 1'b1;

        // Back-to-back adds
        drive(OP_ADD, 32'd3, 32'd4, 32'h0, 2'd2, 32'h10);
        tick();
        drive(OP_ADD, 32'd5, 32'd6, 32'h0, 2'd2, 32'h14);
        #1;
        chk("add1_res", 64'(es_result), 64'd7);
        chk("add1_valid", 64'(es_to_ms_valid), 64'd1);
        chk("add1_pc", 64'(es_pc), 64'h10);
        chk("add1_fwok", 64'(es_fw_data_ok), 64'd1);
        chk("add1_allowin", 64'(ds_if.es_allowin), 64'd1);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("add2_res", 64'(es_result), 64'd11);
        chk("add2_pc", 64'(es_pc), 64'h14);
        tick();
        #1;
        chk("add_idle", 64'(es_to_ms_valid), 64'd0);

        // Divider
        run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_div("mod_m7_2", OP_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_div("divu_9_0", OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF);
        run_div("modu_5_0", OP_MODU, 32'd5, 32'd0, 32'd5);
        run_div("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("mod_min", OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h0);

        // Store/load lanes
        drive(OP_STORE, 32'h1000, 32'h3, 32'hAB, 2'd0, 32'h30);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("stb_en", 64'(data_sram_en), 64'd1);
        chk("stb_we", 64'(data_sram_we), 64'b1000);
        chk("stb_wdata", 64'(data_sram_wdata), 64'hABABABAB);
        chk("stb_addr", 64'(data_sram_addr), 64'h1003);
        tick();
        drive(OP_STORE, 32'h1000, 32'h1, 32'h1234, 2'd1, 32'h34);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("sth_mis_en", 64'(data_sram_en), 64'd0);
        chk("sth_mis_we", 64'(data_sram_we), 64'd0);
        chk("sth_mis_retire", 64'(es_to_ms_valid), 64'd1);
        chk("sth_mis_res", 64'(es_result), 64'h1001);
        tick();
        drive(OP_STORE, 32'h1000, 32'h2, 32'hBEEF, 2'd1, 32'h38);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("sth_we", 64'(data_sram_we), 64'b1100);
        chk("sth_wdata", 64'(data_sram_wdata), 64'hBEEFBEEF);
        tick();
        drive(OP_LOAD, 32'h2000, 32'h4, 32'h0, 2'd2, 32'h3C);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("ldw_en", 64'(data_sram_en), 64'd1);
        chk("ldw_we", 64'(data_sram_we), 64'd0);
        chk("ldw_frommem", 64'(es_res_from_mem), 64'd1);
        chk("ldw_fwok", 64'(es_fw_data_ok), 64'd0);
        chk("ldw_addr", 64'(data_sram_addr), 64'h2004);
        tick();

        // Flush mid-divide
        drive(OP_DIV, 32'd100, 32'd7, 32'h0, 2'd2, 32'h40);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        #1;
        chk("flush_busy_valid", 64'(es_to_ms_valid), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_killed", 64'(es_to_ms_valid), 64'd0);
        chk("flush_allowin", 64'(ds_if.es_allowin), 64'd1);
        drive(OP_ADD, 32'd1, 32'd1, 32'h0, 2'd2, 32'h44);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        #1;
        chk("flush_add_res", 64'(es_result), 64'd2);
        chk("flush_add_valid", 64'(es_to_ms_valid), 64'd1);
        tick();
        run_div("div_after_flush", OP_DIV, 32'd100, 32'd7, 32'd14);

        // Flush with ms_allowin high on a store
        drive(OP_STORE, 32'h1000, 32'h0, 32'h55, 2'd0, 32'h48);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_st_en", 64'(data_sram_en), 64'd0);
        chk("flush_st_we", 64'(data_sram_we), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_st_gone", 64'(es_to_ms_valid), 64'd0);

        // Back-pressure on a store
        ms_allowin = 1'b0;
        drive(OP_STORE, 32'h3000, 32'h0, 32'h11223344, 2'd2, 32'h4C);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_allowin", 64'(ds_if.es_allowin), 64'd0);
            chk("bp_valid", 64'(es_to_ms_valid), 64'd1);
            pulses += int'(data_sram_en);
            tick();
        end
        ms_allowin = 1'b1;
        #1;
        chk("bp_we", 64'(data_sram_we), 64'hF);
        chk("bp_wdata", 64'(data_sram_wdata), 64'h11223344);
        for (int i = 0; i < 4; i++) begin
            pulses += int'(data_sram_en);
            tick();
            #1;
        end
        chk("bp_pulses", 64'(pulses), 64'd1);

        // Asynchronous reset mid-divide
        drive(OP_DIV, 32'd50, 32'd5, 32'h0, 2'd2, 32'h50);
        tick();
        ds_if.ds_to_es_valid = 1'b0;
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(es_to_ms_valid), 64'd0);
        chk("arst_allowin", 64'(ds_if.es_allowin), 64'd1);
        chk("arst_pc", 64'(es_pc), 64'd0);
        chk("arst_fwvalid", 64'(es_fw_valid), 64'd0);
        chk("arst_dest", 64'(es_dest), 64'd0);
        tick();
        resetn = 1'b1;
        run_div("div_after_rst", OP_DIV, 32'd50, 32'd5, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
